// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size encoding.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_type;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables and data replication, load
// extraction with sign/zero extension, and misalignment detection.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  mem_size_type i_size,
    input  logic [1:0]   i_addr_lo,
    input  logic         i_sign,
    input  logic [31:0]  i_wdata,
    input  logic [31:0]  i_rword,
    output logic [3:0]   o_be,
    output logic [31:0]  o_wdata,
    output logic [31:0]  o_rdata,
    output logic         o_misalign
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    assign w_byte = i_addr_lo[0] ? w_half[15:8] : w_half[7:0];

    always_comb begin
        o_be       = '0;
        o_wdata    = i_wdata;
        o_rdata    = i_rword;
        o_misalign = 1'b0;
        case (i_size)
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_misalign = i_addr_lo[0];
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{i_sign & w_half[15]}}, w_half};
            end
            SIZE_WORD: begin
                o_misalign = |i_addr_lo;
                o_be       = '1;
            end
            default: o_misalign = 1'b1;
        endcase
        // An erroring request must never touch storage.
        if (o_misalign) begin
            o_be = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states,
// byte/half/word access and a held response until the initiator accepts it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error
);

    localparam int         DEPTH     = 1 << (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t              r_state, w_next;
    logic [3:0]          r_cnt;
    logic                r_write, r_sign;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [1:0]          r_size;
    logic [31:0]         r_rdata;
    logic                r_error;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept, w_enter_resp;
    logic                w_cur_write, w_cur_sign;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic [31:0]         w_cur_wdata;
    logic [1:0]          w_cur_size;
    logic [ADDR_W-3:0]   w_idx;
    logic [3:0]          w_be;
    logic [31:0]         w_wrep, w_load, w_rword;
    logic                w_misalign;

    assign w_accept     = req_valid && req_ready;
    assign w_enter_resp = (r_state != ST_RESP) && (w_next == ST_RESP);

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live request fields are used instead of the latched copy.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_cur_write = req_write;
            w_cur_sign  = req_sign;
            w_cur_addr  = req_addr;
            w_cur_wdata = req_wdata;
            w_cur_size  = req_size;
        end else begin
            w_cur_write = r_write;
            w_cur_sign  = r_sign;
            w_cur_addr  = r_addr;
            w_cur_wdata = r_wdata;
            w_cur_size  = r_size;
        end
    end

    assign w_idx   = w_cur_addr[ADDR_W-1:2];
    assign w_rword = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_size     (mem_size_type'(w_cur_size)),
        .i_addr_lo  (w_cur_addr[1:0]),
        .i_sign     (w_cur_sign),
        .i_wdata    (w_cur_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wrep),
        .o_rdata    (w_load),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd1) w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE) && !reset;
        rsp_valid = (r_state == ST_RESP);
        rsp_rdata = r_rdata;
        rsp_error = r_error;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_sign  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_sign  <= req_sign;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_size  <= req_size;
            end
            if (r_state == ST_IDLE && w_accept) begin
                r_cnt <= WAIT_INIT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_error <= w_misalign;
                r_rdata <= (w_cur_write || w_misalign) ? '0 : w_load;
            end else if (r_state == ST_RESP && rsp_ready) begin
                r_error <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enter_resp && w_cur_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (1, 3 and 0 wait states) driven with
// directed and random transactions, checked against a byte-array memory model.
module tb_dmem_responder;

    function automatic int wc_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : 0;
    endfunction

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [9:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [1:0]  req_size  [3];
    logic        req_sign  [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_error [3];

    logic [7:0]  mbytes [3][1024];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(wc_of(g))) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_size  (req_size[g]),
            .req_sign  (req_sign[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_error (rsp_error[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: memory is a flat byte array; accesses are little-endian.
    task automatic ref_op(input int k, input logic wr, input logic [9:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                          output logic [31:0] rd, output logic er);
        er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        rd = '0;
        if (!er) begin
            int nb;
            nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            if (wr) begin
                for (int i = 0; i < nb; i++) mbytes[k][int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rd[8*i +: 8] = mbytes[k][int'(a) + i];
                if (sg && nb < 4 && rd[8*nb-1]) begin
                    for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hFF;
                end
            end
        end
    endtask

    task automatic do_txn(input int k, input logic wr, input logic [9:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                          input int hold);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          cyc;
        logic        seen;
        ref_op(k, wr, a, wd, sz, sg, exp_rd, exp_er);
        @(negedge clk);
        req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a;
        req_wdata[k] = wd;   req_size[k]  = sz; req_sign[k] = sg;
        chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_write[k] = 1'($urandom); req_addr[k] = 10'($urandom);
        req_wdata[k] = $urandom;     req_size[k] = 2'($urandom);
        if (hold == 0) rsp_ready[k] = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid[k]) seen = 1'b1;
        end
        chk("rsp_latency", 32'(cyc), 32'(wc_of(k) + 1));
        chk("rsp_rdata", rsp_rdata[k], exp_rd);
        chk("rsp_error", 32'(rsp_error[k]), 32'(exp_er));
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid[k]), 32'd1);
            chk("hold_rdata", rsp_rdata[k], exp_rd);
            chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        chk("post_valid", 32'(rsp_valid[k]), 32'd0);
        chk("post_req_ready", 32'(req_ready[k]), 32'd1);
        chk("post_rdata", rsp_rdata[k], 32'd0);
        chk("post_error", 32'(rsp_error[k]), 32'd0);
        rsp_ready[k] = 1'b0;
    endtask

    initial begin
        logic [31:0] b2b_wd [8];
        logic [31:0] rd_tmp;
        logic        er_tmp;
        logic [31:0] exp_q[$];
        int          idx, last, cyc;
        logic        acc;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0; req_size[k] = '0; req_sign[k] = 1'b0; rsp_ready[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_req_ready", 32'(req_ready[k]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[k], 32'd0);
            chk("rst_rsp_error", 32'(rsp_error[k]), 32'd0);
            rst[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("idle_req_ready", 32'(req_ready[k]), 32'd1);

        // Word store/load, byte lanes with extension, errors, held response.
        do_txn(0, 1'b1, 10'h010, 32'hDEADBEEF, 2'd2, 1'b0, 0);
        do_txn(0, 1'b0, 10'h010, 32'h0,        2'd2, 1'b0, 0);
        do_txn(0, 1'b1, 10'h010, 32'h00000000, 2'd2, 1'b0, 0);
        do_txn(0, 1'b1, 10'h013, 32'h55AA0080, 2'd0, 1'b0, 1);
        do_txn(0, 1'b0, 10'h013, 32'h0,        2'd0, 1'b1, 0);
        do_txn(0, 1'b0, 10'h013, 32'h0,        2'd0, 1'b0, 0);
        do_txn(0, 1'b0, 10'h010, 32'h0,        2'd2, 1'b0, 0);
        do_txn(0, 1'b1, 10'h011, 32'hFFFFFFFF, 2'd1, 1'b0, 0);
        do_txn(0, 1'b0, 10'h010, 32'h0,        2'd2, 1'b0, 0);
        do_txn(0, 1'b0, 10'h010, 32'h0,        2'd3, 1'b0, 0);
        do_txn(0, 1'b0, 10'h010, 32'h0,        2'd2, 1'b0, 5);

        // Random traffic over a pre-initialised region.
        for (int a = 0; a < 64; a += 4) do_txn(0, 1'b1, 10'(a), $urandom, 2'd2, 1'b0, 0);
        repeat (40) begin
            do_txn(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
        end

        // Reset during WAIT aborts the store.
        do_txn(1, 1'b1, 10'h020, 32'hA5A5A5A5, 2'd2, 1'b0, 0);
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 10'h020;
        req_wdata[1] = 32'h12345678; req_size[1] = 2'd2; req_sign[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        chk("abort_req_ready", 32'(req_ready[1]), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        do_txn(1, 1'b0, 10'h020, 32'h0, 2'd2, 1'b0, 0);
        repeat (10) begin
            do_txn(1, 1'($urandom_range(0, 1)), 10'h020 + 10'($urandom_range(0, 3)), $urandom,
                   2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
        end

        // Zero wait states, back-to-back requests, rsp_ready tied high.
        for (int i = 0; i < 4; i++) b2b_wd[i] = $urandom;
        rsp_ready[2] = 1'b1;
        idx = 0; last = -1; cyc = 0;
        @(negedge clk);
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 10'h040;
        req_wdata[2] = b2b_wd[0]; req_size[2] = 2'd2; req_sign[2] = 1'b0;
        while (cyc < 60 && (idx < 8 || exp_q.size() > 0)) begin
            if (rsp_valid[2]) begin
                if (exp_q.size() == 0) chk("b2b_extra_rsp", 32'd1, 32'd0);
                else chk("b2b_rdata", rsp_rdata[2], exp_q.pop_front());
            end
            acc = req_valid[2] && req_ready[2];
            if (acc) begin
                ref_op(2, req_write[2], req_addr[2], req_wdata[2], 2'd2, 1'b0, rd_tmp, er_tmp);
                exp_q.push_back(rd_tmp);
                if (last >= 0) chk("b2b_period", 32'(cyc - last), 32'd2);
                last = cyc;
                idx++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (idx < 8) begin
                    req_write[2] = (idx < 4);
                    req_addr[2]  = 10'h040 + 10'(4 * (idx % 4));
                    req_wdata[2] = (idx < 4) ? b2b_wd[idx] : $urandom;
                end else begin
                    req_valid[2] = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_accept_count", 32'(idx), 32'd8);
        rsp_ready[2] = 1'b0;
        do_txn(2, 1'b0, 10'h044, 32'h0, 2'd1, 1'b1, 2);
        do_txn(2, 1'b0, 10'h04B, 32'h0, 2'd0, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width; storage depth is 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, number of access wait states (0..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_size  input  2  mem_size_type: BYTE=00, HALF=01, WORD=10, 11 reserved.
REQ-011 req_sign  input  1  1 = sign-extend load result, 0 = zero-extend.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 rsp_error  output  1  misaligned or reserved-size request.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE and 0 while reset is asserted.
REQ-018 A request SHALL be accepted when req_valid and req_ready are both 1; all req_* fields are latched on that edge.
REQ-019 req_* fields SHALL be ignored while req_ready is 0.
REQ-020 On acceptance, IDLE SHALL go to WAIT and load the wait counter, or go directly to RESP when WAIT_CYCLES=0.
REQ-021 WAIT SHALL last exactly WAIT_CYCLES cycles, then go to RESP.
REQ-022 The storage access SHALL occur on the edge entering RESP (store commit and load capture).
REQ-023 The error condition SHALL be: HALF with addr[0]=1, WORD with addr[1:0]!=00, or size 11.
REQ-024 An erroring request SHALL not modify storage, and SHALL return rsp_error=1 and rsp_rdata=0.
REQ-025 A store SHALL update only the addressed lanes; other lanes are unchanged.
- BYTE: lane addr[1:0].
- HALF: lanes {addr[1],0} and {addr[1],1}.
- WORD: all four lanes.
REQ-026 A load SHALL extract the addressed byte or halfword into bit 0 upward, extended per req_sign; a WORD load is returned unmodified.
REQ-027 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_error SHALL be held stable until rsp_ready=1.
REQ-028 On the rsp_valid && rsp_ready edge the FSM SHALL return to IDLE.
- rsp_valid falls the next cycle.
- A new request cannot be accepted in that same cycle.
REQ-029 rsp_ready already 1 when rsp_valid rises SHALL complete the handshake in that first RESP cycle.
REQ-030 Minimum transaction period SHALL be WAIT_CYCLES+2 cycles (acceptance to next acceptance).
REQ-031 Outside RESP, rsp_valid SHALL be 0 and rsp_rdata and rsp_error SHALL be 0.

Reset
REQ-032 Reset SHALL force, asynchronously: state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_error 0.
REQ-033 Reset asserted in WAIT SHALL abort the transaction; its store is not committed and no response is issued.
REQ-034 Reset asserted in RESP SHALL drop the pending response; storage committed before reset is retained.
REQ-035 Storage contents SHALL not be reset.

Structure
REQ-036 mem_size_type (BYTE/HALF/WORD encoding) SHALL live in the shared common package; the FSM state enum stays local.
REQ-037 Lane steering SHALL be one combinational sub-module, dmem_lane_align: write byte-enable and data replication, load extraction and extension, misalignment detection.
REQ-038 Storage SHALL be a word array with per-byte write enables.

Verification
REQ-039 Store WORD 0xDEADBEEF @0x010, then load WORD @0x010 -> rsp_rdata=0xDEADBEEF, rsp_error=0, rsp_valid rises WAIT_CYCLES+1 cycles after acceptance.
REQ-040 Store BYTE 0x80 @0x013 over word 0x00000000, then:
- load BYTE signed @0x013 -> 0xFFFFFF80.
- load BYTE unsigned @0x013 -> 0x00000080.
- load WORD @0x010 -> 0x80000000.
REQ-041 Store HALF @0x011 -> rsp_error=1, rsp_rdata=0, word @0x010 unchanged; load size 11 -> rsp_error=1.
REQ-042 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable throughout, req_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-043 Store WORD 0x12345678 @0x020 with reset pulsed during WAIT (WAIT_CYCLES=3) -> no response, rsp_valid=0; a later load @0x020 returns the prior contents.
REQ-044 WAIT_CYCLES=0 with back-to-back requests and rsp_ready tied 1 -> one acceptance every 2 cycles, responses in order.
